// File: rtl/pci_master_req.sv
// PCI bus initiator: requests the bus on a local start, runs one burst write
// (address phase, len data phases, turnaround) and reports done / master abort.
module pci_master_req #(
  parameter int CNT_W     = 4,
  parameter int ABORT_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      addr,
  input  logic [3:0]       cmd,
  input  logic [CNT_W-1:0] len,
  input  logic [31:0]      wdata,
  output logic             wdata_next,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             req_n,
  input  logic             gnt_n,
  input  logic             frame_in_n,
  input  logic             irdy_in_n,
  input  logic             trdy_n,
  output logic             frame_n,
  output logic             irdy_n,
  output logic [31:0]      ad,
  output logic [3:0]       cbe_n,
  output logic             oe
);

  localparam int AW = $clog2(ABORT_CYC + 1);
  localparam logic [AW-1:0]    ABORT_LIM = AW'(ABORT_CYC);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, TURN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [AW-1:0]    abort_q, abort_d;
  logic             err_q, err_d;
  logic [AW-1:0]    abortInc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cmd_q   <= '0;
      rem_q   <= '0;
      abort_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      rem_q   <= rem_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cmd_d    = cmd_q;
    rem_d    = rem_q;
    abort_d  = abort_q;
    err_d    = err_q;
    abortInc = abort_q + AW'(1);
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          addr_d  = addr;
          cmd_d   = cmd;
          rem_d   = len;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!gnt_n && frame_in_n && irdy_in_n) state_d = ADDR;
      end
      ADDR: begin
        abort_d = '0;
        state_d = DATA;
      end
      DATA: begin
        // A ready target always wins over an abort that would fire on the same edge.
        if (!trdy_n) begin
          abort_d = '0;
          if (rem_q == ONE) begin
            err_d   = 1'b0;
            state_d = TURN;
          end else begin
            rem_d = rem_q - ONE;
          end
        end else begin
          if (abort_q != ABORT_LIM) abort_d = abortInc;
          if (abortInc == ABORT_LIM) begin
            err_d   = 1'b1;
            state_d = TURN;
          end
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus drive values decode from the registered state; only wdata and trdy_n pass through.
  always_comb begin
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    req_n      = 1'b1;
    frame_n    = 1'b1;
    irdy_n     = 1'b1;
    oe         = 1'b0;
    ad         = '0;
    cbe_n      = 4'hF;
    wdata_next = 1'b0;
    case (state_q)
      IDLE: busy = 1'b0;
      REQ:  req_n = 1'b0;
      ADDR: begin
        req_n   = 1'b0;
        oe      = 1'b1;
        frame_n = 1'b0;
        ad      = addr_q;
        cbe_n   = cmd_q;
      end
      DATA: begin
        oe         = 1'b1;
        irdy_n     = 1'b0;
        frame_n    = (rem_q == ONE);
        req_n      = (rem_q == ONE);
        ad         = wdata;
        cbe_n      = 4'h0;
        wdata_next = !trdy_n;
      end
      TURN: begin
        oe   = 1'b1;
        done = 1'b1;
        err  = err_q;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pci_master_req.sv
// Bench for pci_master_req: each transfer is planned as a per-cycle table of
// stimulus and expected outputs derived from the bus rules, then replayed.
module tb_pci_master_req;

  localparam int CNT_W     = 4;
  localparam int ABORT_CYC = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      addr;
  logic [3:0]       cmd;
  logic [CNT_W-1:0] len;
  logic [31:0]      wdata;
  logic             wdata_next;
  logic             busy;
  logic             done;
  logic             err;
  logic             req_n;
  logic             gnt_n;
  logic             frame_in_n;
  logic             irdy_in_n;
  logic             trdy_n;
  logic             frame_n;
  logic             irdy_n;
  logic [31:0]      ad;
  logic [3:0]       cbe_n;
  logic             oe;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct packed {
    logic             start;
    logic [31:0]      addr;
    logic [3:0]       cmd;
    logic [CNT_W-1:0] len;
    logic             gntN;
    logic             frameInN;
    logic             irdyInN;
    logic             trdyN;
    logic [31:0]      wdata;
    logic             eReqN;
    logic             eFrameN;
    logic             eIrdyN;
    logic             eOe;
    logic [31:0]      eAd;
    logic [3:0]       eCbeN;
    logic             eBusy;
    logic             eDone;
    logic             eErr;
    logic             eWnext;
    logic             chkBus;
  } cyc_t;

  cyc_t plan[$];

  pci_master_req #(.CNT_W(CNT_W), .ABORT_CYC(ABORT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .cmd(cmd), .len(len),
    .wdata(wdata), .wdata_next(wdata_next), .busy(busy), .done(done), .err(err),
    .req_n(req_n), .gnt_n(gnt_n), .frame_in_n(frame_in_n), .irdy_in_n(irdy_in_n),
    .trdy_n(trdy_n), .frame_n(frame_n), .irdy_n(irdy_n), .ad(ad), .cbe_n(cbe_n), .oe(oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // An idle-looking cycle with random inputs; callers overwrite what matters.
  function automatic cyc_t baseCyc();
    cyc_t c;
    c.start    = 1'($urandom);
    c.addr     = $urandom;
    c.cmd      = 4'($urandom);
    c.len      = CNT_W'($urandom);
    c.gntN     = 1'($urandom);
    c.frameInN = 1'($urandom);
    c.irdyInN  = 1'($urandom);
    c.trdyN    = 1'($urandom);
    c.wdata    = $urandom;
    c.eReqN    = 1'b1;
    c.eFrameN  = 1'b1;
    c.eIrdyN   = 1'b1;
    c.eOe      = 1'b0;
    c.eAd      = '0;
    c.eCbeN    = 4'hF;
    c.eBusy    = 1'b0;
    c.eDone    = 1'b0;
    c.eErr     = 1'b0;
    c.eWnext   = 1'b0;
    c.chkBus   = 1'b1;
    return c;
  endfunction

  task automatic addIdle();
    cyc_t c;
    c = baseCyc();
    if (c.start) c.len = '0;
    plan.push_back(c);
  endtask

  task automatic addData(input int rem, input logic trdy);
    cyc_t c;
    c = baseCyc();
    c.trdyN   = trdy;
    c.eBusy   = 1'b1;
    c.eOe     = 1'b1;
    c.eIrdyN  = 1'b0;
    c.eFrameN = (rem == 1);
    c.eReqN   = (rem == 1);
    c.eAd     = c.wdata;
    c.eCbeN   = 4'h0;
    c.eWnext  = !trdy;
    plan.push_back(c);
  endtask

  // waits[w] = target wait cycles before word w; abortWord = word that never gets trdy (-1: none).
  task automatic addTxn(input int L, input logic [31:0] a, input logic [3:0] cm, input int R,
                        input int waits[16], input int abortWord);
    cyc_t c;
    int   rem;
    logic aborted;
    c = baseCyc();
    c.start = 1'b1;
    c.len   = CNT_W'(L);
    c.addr  = a;
    c.cmd   = cm;
    plan.push_back(c);
    for (int r = 0; r < R; r++) begin
      c = baseCyc();
      c.eReqN = 1'b0;
      c.eBusy = 1'b1;
      if (r < R - 1) begin
        while (!c.gntN && c.frameInN && c.irdyInN) begin
          c.gntN     = 1'($urandom);
          c.frameInN = 1'($urandom);
          c.irdyInN  = 1'($urandom);
        end
      end else begin
        c.gntN     = 1'b0;
        c.frameInN = 1'b1;
        c.irdyInN  = 1'b1;
      end
      plan.push_back(c);
    end
    c = baseCyc();
    c.eReqN   = 1'b0;
    c.eBusy   = 1'b1;
    c.eOe     = 1'b1;
    c.eFrameN = 1'b0;
    c.eAd     = a;
    c.eCbeN   = cm;
    plan.push_back(c);
    rem     = L;
    aborted = 1'b0;
    for (int w = 0; w < L && !aborted; w++) begin
      if (w == abortWord) begin
        for (int k = 0; k < ABORT_CYC; k++) addData(rem, 1'b1);
        aborted = 1'b1;
      end else begin
        for (int k = 0; k < waits[w]; k++) addData(rem, 1'b1);
        addData(rem, 1'b0);
        rem--;
      end
    end
    c = baseCyc();
    c.eBusy  = 1'b1;
    c.eOe    = 1'b1;
    c.eDone  = 1'b1;
    c.eErr   = aborted;
    c.chkBus = 1'b0;
    plan.push_back(c);
  endtask

  task automatic applyStimulus(input cyc_t c);
    start      = c.start;
    addr       = c.addr;
    cmd        = c.cmd;
    len        = c.len;
    gnt_n      = c.gntN;
    frame_in_n = c.frameInN;
    irdy_in_n  = c.irdyInN;
    trdy_n     = c.trdyN;
    wdata      = c.wdata;
  endtask

  task automatic checkCycle(input cyc_t c, input int n);
    string t;
    t = $sformatf("cyc%0d", n);
    checkOutput({t, ".req_n"},      32'(req_n),      32'(c.eReqN));
    checkOutput({t, ".frame_n"},    32'(frame_n),    32'(c.eFrameN));
    checkOutput({t, ".irdy_n"},     32'(irdy_n),     32'(c.eIrdyN));
    checkOutput({t, ".oe"},         32'(oe),         32'(c.eOe));
    checkOutput({t, ".busy"},       32'(busy),       32'(c.eBusy));
    checkOutput({t, ".done"},       32'(done),       32'(c.eDone));
    checkOutput({t, ".err"},        32'(err),        32'(c.eErr));
    checkOutput({t, ".wdata_next"}, 32'(wdata_next), 32'(c.eWnext));
    if (c.chkBus) begin
      checkOutput({t, ".ad"},    ad,           c.eAd);
      checkOutput({t, ".cbe_n"}, 32'(cbe_n),   32'(c.eCbeN));
    end
  endtask

  task automatic runPlan(input int maxCyc);
    cyc_t c;
    int   n;
    n = 0;
    while (plan.size() > 0 && n < maxCyc) begin
      c = plan.pop_front();
      @(posedge clk);
      #1;
      applyStimulus(c);
      @(negedge clk);
      checkCycle(c, n);
      n++;
    end
  endtask

  task automatic checkResetOutputs(input string t);
    checkOutput({t, ".req_n"},      32'(req_n),      32'd1);
    checkOutput({t, ".frame_n"},    32'(frame_n),    32'd1);
    checkOutput({t, ".irdy_n"},     32'(irdy_n),     32'd1);
    checkOutput({t, ".oe"},         32'(oe),         32'd0);
    checkOutput({t, ".ad"},         ad,              32'd0);
    checkOutput({t, ".cbe_n"},      32'(cbe_n),      32'hF);
    checkOutput({t, ".busy"},       32'(busy),       32'd0);
    checkOutput({t, ".done"},       32'(done),       32'd0);
    checkOutput({t, ".err"},        32'(err),        32'd0);
    checkOutput({t, ".wdata_next"}, 32'(wdata_next), 32'd0);
  endtask

  initial begin
    int waits[16];
    int L;
    rst_n      = 1'b0;
    start      = 1'b0;
    addr       = '0;
    cmd        = '0;
    len        = '0;
    wdata      = '0;
    gnt_n      = 1'b1;
    frame_in_n = 1'b1;
    irdy_in_n  = 1'b1;
    trdy_n     = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (waits[i]) waits[i] = 0;
    addTxn(1, 32'h1000_0000, 4'h7, 1, waits, -1);
    addIdle();
    waits[1] = 2;
    addTxn(4, 32'hA5A5_0040, 4'h7, 1, waits, -1);
    waits[1] = 0;
    addTxn(2, 32'h0000_0100, 4'h3, 8, waits, -1);
    addTxn(3, 32'hDEAD_BEE0, 4'h7, 1, waits, 0);
    addIdle();
    waits[14] = 7;
    addTxn(15, 32'h1234_5678, 4'hB, 2, waits, -1);
    waits[14] = 0;
    waits[0]  = 7;
    addTxn(3, 32'h0BAD_F00D, 4'h7, 1, waits, 1);
    runPlan(100000);

    for (int t = 0; t < 30; t++) begin
      L = $urandom_range(1, 15);
      foreach (waits[i]) begin
        case ($urandom_range(0, 5))
          0, 1, 2: waits[i] = 0;
          3:       waits[i] = 1;
          4:       waits[i] = 2;
          default: waits[i] = 7;
        endcase
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) addIdle();
      addTxn(L, $urandom, 4'($urandom), $urandom_range(1, 6), waits,
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, L - 1) : -1);
    end
    addIdle();
    runPlan(100000);

    foreach (waits[i]) waits[i] = 0;
    addTxn(5, 32'hCAFE_0000, 4'h7, 1, waits, -1);
    runPlan(5);
    #1 rst_n = 1'b0;
    start = 1'b0;
    #1;
    checkResetOutputs("midreset");
    plan.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    addIdle();
    addTxn(2, 32'h4444_0000, 4'h6, 1, waits, -1);
    addIdle();
    runPlan(100000);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
